// File: rtl/fetch_unit.sv
// fetch_unit: LEGv8 instruction fetch stage.
//   Owns the PC, fetches words from a variable-latency instruction memory
//   over req/ack, holds each word in an output register and hands it to
//   decode over a valid/ready handshake. A consumed word may carry a branch
//   redirect; a misaligned redirect target raises a sticky fault and halts.
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-low reset
//   imem_req/addr     - fetch request and address (address is the PC)
//   imem_ack/rdata    - one-cycle ack pulse with the instruction word
//   instr_valid       - instr/instr_pc hold an unconsumed instruction
//   dec_ready         - decode accepts the held instruction this cycle
//   instr/opcode      - held instruction word and its [31:21] opcode field
//   instr_pc          - address the held instruction was fetched from
//   branch_taken/target - redirect, qualified by the consume handshake
//   fault             - sticky misaligned-target fault
module fetch_unit #(
  parameter int unsigned  N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [N-1:0]  imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic          instr_valid,
  input  logic          dec_ready,
  output logic [31:0]   instr,
  output logic [10:0]   opcode,
  output logic [N-1:0]  instr_pc,
  input  logic          branch_taken,
  input  logic [N-1:0]  branch_target,
  output logic          fault
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]   r_state;
  logic [N-1:0] r_pc;
  logic [N-1:0] r_instr_pc;
  logic [31:0]  r_instr;
  logic         r_fault;

  logic         w_consume;
  logic         w_redirect;
  logic         w_misaligned;
  logic [N-1:0] w_pc_inc;

  // Increment wraps silently at 2^N.
  assign w_pc_inc = r_pc + N'(4);

  always_comb begin
    w_consume    = (r_state == S_VALID) && dec_ready;
    w_redirect   = w_consume && branch_taken;
    w_misaligned = (branch_target[1:0] != 2'b00);
  end

  // Control inputs are only looked at inside the state that qualifies them,
  // so stray acks, ready or branch pulses elsewhere cannot move the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: r_state <= S_FETCH;
        S_FETCH: begin
          if (imem_ack) begin
            r_instr    <= imem_rdata;
            r_instr_pc <= r_pc;
            r_pc       <= w_pc_inc;
            r_state    <= S_VALID;
          end
        end
        S_VALID: begin
          if (w_consume) begin
            if (w_redirect && w_misaligned) begin
              r_fault <= 1'b1;
              r_state <= S_HALT;
            end else begin
              r_state <= S_FETCH;
              if (w_redirect) r_pc <= branch_target;
            end
          end
        end
        default: r_state <= r_state;  // HALT: only reset leaves
      endcase
    end
  end

  assign imem_req    = (r_state == S_FETCH);
  assign instr_valid = (r_state == S_VALID);
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign opcode      = r_instr[31:21];
  assign instr_pc    = r_instr_pc;
  assign fault       = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        dec_ready;
  logic [31:0] instr;
  logic [10:0] opcode;
  logic [63:0] instr_pc;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        fault;

  // second instance exercising PC wrap from the top of the address space
  logic        w_req;
  logic [63:0] w_addr;
  logic        w_ack;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [10:0] w_opc;
  logic [63:0] w_ipc;
  logic        w_fault;

  assign w_ack = w_req;

  always #5 clk = ~clk;

  fetch_unit #(.N(64), .RESET_PC(64'h0)) u_dut (
    .clk(clk), .reset(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .dec_ready(dec_ready),
    .instr(instr), .opcode(opcode), .instr_pc(instr_pc),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .fault(fault)
  );

  fetch_unit #(.N(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk(clk), .reset(rst_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(32'hD503201F),
    .instr_valid(w_valid), .dec_ready(1'b1),
    .instr(w_instr), .opcode(w_opc), .instr_pc(w_ipc),
    .branch_taken(1'b0), .branch_target(64'h0),
    .fault(w_fault)
  );

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // reference model: next fetch address and the words handed to decode
  logic [63:0] model_pc;
  logic [31:0] exp_i[$];
  logic [63:0] exp_pc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] rand_aligned();
    logic [63:0] t;
    t = {32'h0, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
    return t;
  endfunction

  // Monitor: a new instruction appears on each rising edge of instr_valid;
  // it must match the oldest outstanding expectation and stay stable.
  initial begin
    logic        prev_v;
    logic [31:0] cur_i;
    logic [63:0] cur_pc;
    prev_v = 1'b0;
    cur_i  = '0;
    cur_pc = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && instr_valid) begin
        if (!prev_v) begin
          if (exp_i.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_valid: instr %h at pc %h with empty scoreboard", instr, instr_pc);
          end else begin
            cur_i  = exp_i.pop_front();
            cur_pc = exp_pc.pop_front();
          end
        end
        chk("instr", 64'(instr), 64'(cur_i));
        chk("instr_pc", instr_pc, cur_pc);
        chk("opcode", 64'(opcode), 64'(cur_i[31:21]));
      end
      prev_v = rst_n && instr_valid;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0; dec_ready = 1'b0; branch_taken = 1'b0;
    exp_i.delete(); exp_pc.delete();
    model_pc = 64'h0;
    #1;
    chk("rst_imem_req", 64'(imem_req), 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_instr_pc", instr_pc, 64'd0);
    chk("rst_imem_addr", imem_addr, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("boot_no_req", 64'(imem_req), 64'd0);
  endtask

  // One full transaction: wait for the request, ack after lat cycles,
  // stall decode for hold cycles, then consume (optionally branching).
  task automatic fetch_one(input logic [31:0] w, input int unsigned lat, input int unsigned hold,
                           input bit br_nc, input bit br, input logic [63:0] tgt,
                           output int unsigned waited);
    waited = 0;
    while (!imem_req && waited < 20) begin
      imem_ack = ($urandom_range(0, 3) == 0); imem_rdata = $urandom;
      dec_ready = 1'($urandom_range(0, 1)); branch_taken = 1'($urandom_range(0, 1));
      branch_target = rand_aligned();
      @(negedge clk);
      waited++;
    end
    dec_ready = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
    if (!imem_req) begin
      n_total++;
      $display("FAIL req_timeout: imem_req=%b after %0d cycles, expected 1", imem_req, waited);
      return;
    end
    for (int unsigned i = 0; i < lat; i++) begin
      imem_ack = 1'b0; imem_rdata = $urandom;
      dec_ready = 1'($urandom_range(0, 1)); branch_taken = 1'($urandom_range(0, 1));
      branch_target = rand_aligned();
      chk("imem_addr_wait", imem_addr, model_pc);
      chk("imem_req_wait", 64'(imem_req), 64'd1);
      @(negedge clk);
    end
    chk("imem_addr", imem_addr, model_pc);
    imem_ack = 1'b1; imem_rdata = w;
    dec_ready = 1'($urandom_range(0, 1)); branch_taken = 1'($urandom_range(0, 1));
    exp_i.push_back(w); exp_pc.push_back(model_pc);
    model_pc = model_pc + 64'd4;
    @(negedge clk);
    chk("valid_after_ack", 64'(instr_valid), 64'd1);
    for (int unsigned i = 0; i < hold; i++) begin
      imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
      dec_ready = 1'b0; branch_taken = br_nc; branch_target = rand_aligned();
      @(negedge clk);
    end
    imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
    dec_ready = 1'b1; branch_taken = br; branch_target = tgt;
    if (br && tgt[1:0] == 2'b00) model_pc = tgt;
    @(negedge clk);
    dec_ready = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned wt;
    logic [31:0] w;
    logic [63:0] pc_saved;
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    dec_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
    model_pc = 64'h0;
    @(negedge clk);

    // 1: back-to-back fetches at 0x0, 0x4, 0x8
    do_reset();
    fetch_one($urandom, 0, 0, 0, 0, 64'h0, wt);
    for (int k = 0; k < 2; k++) begin
      fetch_one($urandom, 0, 0, 0, 0, 64'h0, wt);
      chk("back_to_back", 64'(wt), 64'd0);
    end
    chk("seq_next_addr", imem_addr, 64'hC);

    // 2: LDUR with 3-cycle latency, decode stalled 5 cycles
    do_reset();
    fetch_one(32'hF8400001, 3, 5, 0, 0, 64'h0, wt);
    chk("ldur_opcode", 64'(opcode), 64'(11'b111_1100_0010));
    chk("ldur_next_addr", imem_addr, 64'h4);

    // 3: redirect on consume; branch without ready is ignored
    do_reset();
    fetch_one($urandom, 1, 0, 0, 0, 64'h0, wt);
    fetch_one($urandom, 0, 1, 0, 0, 64'h0, wt);
    fetch_one($urandom, 0, 0, 0, 1, 64'h40, wt);
    chk("redirect_addr", imem_addr, 64'h40);
    fetch_one($urandom, 2, 0, 0, 0, 64'h0, wt);
    chk("after_redirect_addr", imem_addr, 64'h44);
    fetch_one($urandom, 0, 0, 0, 0, 64'h0, wt);
    fetch_one($urandom, 0, 2, 1, 0, 64'h0, wt);
    chk("no_redirect_addr", imem_addr, 64'h4C);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      fetch_one($urandom, $urandom_range(0, 4), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                rand_aligned(), wt);
    end

    // 4: misaligned redirect halts with a sticky fault
    w = $urandom;
    pc_saved = model_pc;
    fetch_one(w, 1, 1, 0, 1, 64'h42, wt);
    chk("fault_set", 64'(fault), 64'd1);
    for (int k = 0; k < 12; k++) begin
      imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
      dec_ready = 1'($urandom_range(0, 1)); branch_taken = 1'($urandom_range(0, 1));
      branch_target = rand_aligned();
      @(negedge clk);
      chk("halt_req", 64'(imem_req), 64'd0);
      chk("halt_valid", 64'(instr_valid), 64'd0);
    end
    chk("halt_instr", 64'(instr), 64'(w));
    chk("halt_instr_pc", instr_pc, pc_saved);
    chk("halt_fault", 64'(fault), 64'd1);
    do_reset();
    fetch_one($urandom, 0, 0, 0, 0, 64'h0, wt);
    fetch_one($urandom, 1, 0, 0, 0, 64'h0, wt);

    // 6: reset during a pending fetch, with acks during and just after reset
    do_reset();
    @(negedge clk);
    chk("t6_req", 64'(imem_req), 64'd1);
    imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = $urandom;
    exp_i.delete(); exp_pc.delete(); model_pc = 64'h0;
    #1;
    chk("t6_rst_req", 64'(imem_req), 64'd0);
    chk("t6_rst_valid", 64'(instr_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_valid", 64'(instr_valid), 64'd0);
    chk("t6_req_after", 64'(imem_req), 64'd1);
    chk("t6_addr", imem_addr, 64'h0);
    imem_ack = 1'b0;
    fetch_one($urandom, 1, 0, 0, 0, 64'h0, wt);

    // 5: PC wrap on the second instance
    do_reset();
    wt = 0;
    while (!w_valid && wt < 10) begin
      @(negedge clk);
      wt++;
    end
    chk("wrap_valid", 64'(w_valid), 64'd1);
    chk("wrap_instr_pc", w_ipc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_next_addr", w_addr, 64'h0);
    chk("wrap_instr", 64'(w_instr), 64'hD503201F);

    repeat (3) @(negedge clk);
    chk("sb_drain", 64'(exp_i.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage for the LEGv8 core, directly upstream of the main decoder.
- Owns the PC and issues requests to a variable-latency instruction memory over a req/ack interface.
- Holds each fetched word in an output register. The word's opcode field, instr[31:21], drives the decoder's Op input.
- Hands words to decode over a valid/ready handshake and accepts a branch redirect from the consuming stage.

Parameters:
N, 64, PC/address width in bits
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  N  fetch address; equals pc
imem_ack  in  1  single-cycle pulse: imem_rdata is valid this cycle
imem_rdata  in  32  instruction word
instr_valid  out  1  instr/instr_pc hold an unconsumed instruction
dec_ready  in  1  decode accepts instruction this cycle
instr  out  32  fetched instruction
opcode  out  11  instr[31:21], to decoder Op
instr_pc  out  N  address instr was fetched from
branch_taken  in  1  redirect, qualified by the consume handshake
branch_target  in  N  redirect target
fault  out  1  sticky misaligned-target fault

Behaviour:
- Reset (reset=0, takes effect immediately, no clock needed):
  - pc=RESET_PC, state=BOOT.
  - instr=0, instr_pc=0, instr_valid=0, imem_req=0, fault=0.
- Outputs are decoded from registered state only; no input-to-output combinational path.
  - imem_req = (state==FETCH).
  - instr_valid = (state==VALID).
  - imem_addr = pc.
  - opcode = instr[31:21].
- BOOT: unconditionally go to FETCH next cycle. The first request is therefore seen on the first edge after reset release plus one.
- FETCH:
  - imem_req=1; imem_addr is stable until ack.
  - imem_ack may arrive in the first FETCH cycle or any later one.
  - On a cycle with imem_ack=1: instr<=imem_rdata, instr_pc<=pc, pc<=pc+4 (mod 2^N, wraps silently), state<=VALID.
  - dec_ready and branch_taken are ignored in FETCH.
- VALID:
  - instr_valid=1; instr and instr_pc are held stable until consumed.
  - Consume = instr_valid & dec_ready. On consume, state<=FETCH.
  - On consume with branch_taken=1 and branch_target[1:0]==0: pc<=branch_target, overriding the increment.
  - On consume with branch_taken=1 and branch_target[1:0]!=0: fault<=1, state<=HALT, pc unchanged.
  - branch_taken without dec_ready is ignored.
- HALT:
  - imem_req=0, instr_valid=0.
  - instr and instr_pc keep their last values.
  - Exit only via reset.
- imem_ack outside FETCH is ignored, including a stale ack that arrives after a reset mid-request.
- Throughput: at most one instruction per 2 cycles (FETCH with immediate ack, then VALID with dec_ready=1).
- Reset asserted mid-FETCH or mid-VALID: the in-flight request and held instruction are discarded; the next fetch address is RESET_PC.
- X on imem_rdata is captured as-is. X on control inputs outside their qualifying state must not change state.

Test Plan:
1. Reset release, imem_ack tied to imem_req, dec_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; instr_pc matches each; instr_valid pulses every 2nd cycle.
2. Reset, return 0xF8400001 (LDUR) with 3-cycle ack latency, dec_ready=0 for 5 cycles -> imem_addr=0 stable while waiting; opcode=11'b111_1100_0010; instr_valid stays 1 and instr is unchanged until dec_ready=1; next imem_addr=0x4.
3. Word at 0x8 consumed with branch_taken=1, branch_target=0x40 -> next imem_addr=0x40, then 0x44. Same branch_taken=1 with dec_ready=0 -> no redirect; next fetch 0xC after consume.
4. Consume with branch_taken=1, branch_target=0x42 -> fault=1; imem_req and instr_valid stay 0 for 10+ cycles; reset clears fault and fetch restarts at 0x0.
5. RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, one fetch -> instr_pc=FFFF_FFFF_FFFF_FFFC, next imem_addr=0x0.
6. Assert reset while FETCH is waiting, pulse imem_ack during and just after reset -> pulse ignored; instr_valid=0; first request after release at 0x0.
